// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity bit positions, bit timing
// constants and the frame configuration struct used by both RX and TX.
package uart_pkg;

   localparam int PAR_PCE        = 0;
   localparam int PAR_PS         = 1;
   localparam int TICKS_PER_BIT  = 8;
   localparam int IDLE_BIT_COUNT = 10;
   localparam int SAMPLE_FIRST   = 3;
   localparam int SAMPLE_SECOND  = 4;
   localparam int SAMPLE_DECIDE  = 5;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP1,
      RX_STOP2
   } rx_state_t;

   typedef struct packed {
      logic [2:0]  data_length;
      logic        stop;
      logic [1:0]  parity;
      logic [19:0] clock_divider;
   } uart_config_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one tick every (divider+1) clocks while enabled,
// held at zero when disabled and restartable with a synchronous clear.
module uart_baud_tick (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        clear,
   input  logic [19:0] divider,
   output logic        tick
);

   logic [19:0] count;

   assign tick = enable && !clear && (count >= divider);

   // The >= compare keeps the counter bounded even if the divider shrinks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!enable || clear) begin
         count <= '0;
      end else if (count >= divider) begin
         count <= '0;
      end else begin
         count <= count + 20'd1;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive engine: synchronises rxd, samples frames with 8x oversampling and
// pushes good bytes into a valid/ready stream while flagging errors, break and idle.
module uart_rx_ctrl
   import uart_pkg::*;
(
   input  logic        io_mainClk,
   input  logic        resetCtrl_systemResetn,
   input  logic [2:0]  io_config_frame_dataLength,
   input  logic        io_config_frame_stop,
   input  logic [1:0]  io_config_frame_parity,
   input  logic [19:0] io_config_clockDivider,
   input  logic        io_uart_rxen,
   input  logic        io_uart_rxd,
   output logic        io_read_valid,
   input  logic        io_read_ready,
   output logic [7:0]  io_read_payload,
   output logic        io_readError,
   output logic        io_overrun,
   output logic        io_readBreak,
   output logic        io_rxIdle
);

   logic         rxd_meta;
   logic         rxd_sync;
   logic         rxd_prev;

   uart_config_t cfg;
   rx_state_t    state;
   logic [2:0]   phase;
   logic [2:0]   bit_idx;
   logic         sample_a;
   logic         sample_b;
   logic [7:0]   shift_reg;
   logic         par_acc;
   logic         par_bad;
   logic         stop_bad;
   logic         any_one;

   logic         idle_armed;
   logic         win_ok;
   logic [3:0]   idle_cnt;

   logic         valid_q;
   logic [7:0]   payload_q;
   logic         read_error_q;
   logic         overrun_q;
   logic         break_q;
   logic         idle_q;

   logic         tick;
   logic         start_edge;
   logic         maj;
   logic         decide;
   logic         wrap;
   logic         last_stop;
   logic         frame_bad;
   logic         frame_break;

   // Reset to 1 so a line held low through reset does not look like an edge
   always_ff @(posedge io_mainClk or negedge resetCtrl_systemResetn) begin
      if (!resetCtrl_systemResetn) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_meta <= io_uart_rxd;
         rxd_sync <= rxd_meta;
         rxd_prev <= rxd_sync;
      end
   end

   assign start_edge  = (state == RX_IDLE) && io_uart_rxen && rxd_prev && !rxd_sync;
   assign maj         = majority3(sample_a, sample_b, rxd_sync);
   assign decide      = tick && (phase == 3'(SAMPLE_DECIDE));
   assign wrap        = tick && (phase == 3'(TICKS_PER_BIT - 1));
   assign last_stop   = (state == RX_STOP2) || ((state == RX_STOP1) && !cfg.stop);
   assign frame_bad   = par_bad || stop_bad || !maj;
   assign frame_break = !any_one && !maj;

   uart_baud_tick u_tick (
      .clk     (io_mainClk),
      .rst_n   (resetCtrl_systemResetn),
      .enable  (io_uart_rxen),
      .clear   (start_edge),
      .divider (cfg.clock_divider),
      .tick    (tick)
   );

   // Receiver FSM, idle detector and output stream register; later assignments
   // in this block deliberately override the defaults at the top.
   always_ff @(posedge io_mainClk or negedge resetCtrl_systemResetn) begin
      if (!resetCtrl_systemResetn) begin
         cfg          <= '0;
         state        <= RX_IDLE;
         phase        <= '0;
         bit_idx      <= '0;
         sample_a     <= 1'b0;
         sample_b     <= 1'b0;
         shift_reg    <= '0;
         par_acc      <= 1'b0;
         par_bad      <= 1'b0;
         stop_bad     <= 1'b0;
         any_one      <= 1'b0;
         idle_armed   <= 1'b0;
         win_ok       <= 1'b0;
         idle_cnt     <= '0;
         valid_q      <= 1'b0;
         payload_q    <= '0;
         read_error_q <= 1'b0;
         overrun_q    <= 1'b0;
         break_q      <= 1'b0;
         idle_q       <= 1'b0;
      end else begin
         read_error_q <= 1'b0;
         overrun_q    <= 1'b0;
         idle_q       <= 1'b0;

         if (valid_q && io_read_ready) begin
            valid_q <= 1'b0;
         end
         if (break_q && rxd_sync) begin
            break_q <= 1'b0;
         end

         if (tick) begin
            phase <= phase + 3'd1;
         end
         if (tick && (phase == 3'(SAMPLE_FIRST))) begin
            sample_a <= rxd_sync;
         end
         if (tick && (phase == 3'(SAMPLE_SECOND))) begin
            sample_b <= rxd_sync;
         end

         // Idle windows are aligned to the same tick phase the frame left off on
         if (idle_armed && (state == RX_IDLE)) begin
            if (wrap) begin
               if (win_ok && rxd_sync) begin
                  if (idle_cnt == 4'(IDLE_BIT_COUNT - 1)) begin
                     idle_q     <= 1'b1;
                     idle_armed <= 1'b0;
                     idle_cnt   <= '0;
                  end else begin
                     idle_cnt <= idle_cnt + 4'd1;
                  end
               end else begin
                  idle_cnt <= '0;
               end
               win_ok <= 1'b1;
            end else if (!rxd_sync) begin
               win_ok <= 1'b0;
            end
         end

         if (!io_uart_rxen) begin
            state <= RX_IDLE;
            phase <= '0;
         end else begin
            case (state)
               RX_IDLE: begin
                  if (start_edge) begin
                     state      <= RX_START;
                     phase      <= '0;
                     cfg        <= '{io_config_frame_dataLength, io_config_frame_stop,
                                     io_config_frame_parity, io_config_clockDivider};
                     shift_reg  <= '0;
                     par_acc    <= 1'b0;
                     par_bad    <= 1'b0;
                     stop_bad   <= 1'b0;
                     any_one    <= 1'b0;
                     idle_armed <= 1'b0;
                     idle_cnt   <= '0;
                  end
               end
               RX_START: begin
                  if (decide && maj) begin
                     state <= RX_IDLE;
                  end else if (wrap) begin
                     state   <= RX_DATA;
                     bit_idx <= '0;
                  end
               end
               RX_DATA: begin
                  if (decide) begin
                     shift_reg[bit_idx] <= maj;
                     par_acc            <= par_acc ^ maj;
                     any_one            <= any_one | maj;
                  end
                  if (wrap) begin
                     if (bit_idx == cfg.data_length) begin
                        state <= cfg.parity[PAR_PCE] ? RX_PARITY : RX_STOP1;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                     end
                  end
               end
               RX_PARITY: begin
                  if (decide) begin
                     par_bad <= (maj != (par_acc ^ cfg.parity[PAR_PS]));
                     any_one <= any_one | maj;
                  end
                  if (wrap) begin
                     state <= RX_STOP1;
                  end
               end
               RX_STOP1, RX_STOP2: begin
                  if (decide && last_stop) begin
                     state      <= RX_IDLE;
                     idle_armed <= 1'b1;
                     idle_cnt   <= '0;
                     win_ok     <= 1'b0;
                     if (frame_break) begin
                        read_error_q <= 1'b1;
                        break_q      <= 1'b1;
                     end else if (frame_bad) begin
                        read_error_q <= 1'b1;
                     end else if (valid_q && !io_read_ready) begin
                        overrun_q <= 1'b1;
                     end else begin
                        payload_q <= shift_reg;
                        valid_q   <= 1'b1;
                     end
                  end else if (decide) begin
                     stop_bad <= !maj;
                     any_one  <= any_one | maj;
                  end
                  if (wrap && !last_stop) begin
                     state <= RX_STOP2;
                  end
               end
               default: state <= RX_IDLE;
            endcase
         end
      end
   end

   assign io_read_valid   = valid_q;
   assign io_read_payload = payload_q;
   assign io_readError    = read_error_q;
   assign io_overrun      = overrun_q;
   assign io_readBreak    = break_q;
   assign io_rxIdle       = idle_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl: frames are built bit by bit from
// the configured format and results are checked against hand-derived values.
module tb_uart_rx_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  cfg_len;
   logic        cfg_stop;
   logic [1:0]  cfg_parity;
   logic [19:0] cfg_div;
   logic        rxen;
   logic        rxd;
   logic        valid;
   logic        ready;
   logic [7:0]  payload;
   logic        read_error;
   logic        overrun;
   logic        read_break;
   logic        rx_idle;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] push_q[$];
   int err_n  = 0;
   int ovr_n  = 0;
   int idle_n = 0;

   always #5 clk = ~clk;

   uart_rx_ctrl dut (
      .io_mainClk                 (clk),
      .resetCtrl_systemResetn     (rst_n),
      .io_config_frame_dataLength (cfg_len),
      .io_config_frame_stop       (cfg_stop),
      .io_config_frame_parity     (cfg_parity),
      .io_config_clockDivider     (cfg_div),
      .io_uart_rxen               (rxen),
      .io_uart_rxd                (rxd),
      .io_read_valid              (valid),
      .io_read_ready              (ready),
      .io_read_payload            (payload),
      .io_readError               (read_error),
      .io_overrun                 (overrun),
      .io_readBreak               (read_break),
      .io_rxIdle                  (rx_idle)
   );

   // Event recorder: handshakes and one-cycle pulses sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid && ready) push_q.push_back(payload);
         if (read_error) err_n++;
         if (overrun) ovr_n++;
         if (rx_idle) idle_n++;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int bit_clks();
      return (int'(cfg_div) + 1) * 8;
   endfunction

   task automatic drive_bits(input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         rxd = bits[i];
         wait_clks(bit_clks());
      end
   endtask

   task automatic build_frame(input logic [7:0] data, input bit bad_parity,
                              output logic [15:0] bits, output int n);
      logic p;
      bits = '0;
      n = 1;
      p = cfg_parity[1];
      for (int i = 0; i <= int'(cfg_len); i++) begin
         bits[n] = data[i];
         p = p ^ data[i];
         n++;
      end
      if (cfg_parity[0]) begin
         bits[n] = p ^ bad_parity;
         n++;
      end
      bits[n] = 1'b1;
      n++;
      if (cfg_stop) begin
         bits[n] = 1'b1;
         n++;
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input bit bad_parity);
      logic [15:0] bits;
      int n;
      build_frame(data, bad_parity, bits, n);
      drive_bits(bits, n);
   endtask

   task automatic test_reset();
      tests_run++;
      if ({valid, payload, read_error, overrun, read_break, rx_idle} !== 13'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got %h, required 0",
                  {valid, payload, read_error, overrun, read_break, rx_idle});
      end
      rst_n = 1'b1;
      wait_clks(4);
      tests_run++;
      if ({valid, payload, read_error, read_break} !== 11'h0) begin
         tests_failed++;
         $display("[TB] FAIL post_reset_outputs: got %h, required 0",
                  {valid, payload, read_error, read_break});
      end
   endtask

   task automatic test_8n1();
      int p0, e0, i0, waited;
      p0 = push_q.size(); e0 = err_n; i0 = idle_n;
      send_frame(8'h55, 1'b0);
      send_frame(8'hA3, 1'b0);
      wait_clks(2);
      tests_run++;
      if (push_q.size() - p0 !== 2) begin
         tests_failed++;
         $display("[TB] FAIL 8n1_push_count: got %0d, required 2", push_q.size() - p0);
      end else begin
         tests_run++;
         if (push_q[p0] !== 8'h55) begin
            tests_failed++;
            $display("[TB] FAIL 8n1_byte0: got %h, required 55", push_q[p0]);
         end
         tests_run++;
         if (push_q[p0+1] !== 8'hA3) begin
            tests_failed++;
            $display("[TB] FAIL 8n1_byte1: got %h, required a3", push_q[p0+1]);
         end
      end
      tests_run++;
      if (err_n - e0 !== 0) begin
         tests_failed++;
         $display("[TB] FAIL 8n1_errors: got %0d, required 0", err_n - e0);
      end
      waited = 2;
      while (idle_n == i0 && waited < 600) begin
         wait_clks(1);
         waited++;
      end
      tests_run++;
      if (idle_n - i0 !== 1) begin
         tests_failed++;
         $display("[TB] FAIL 8n1_idle_pulse: got %0d pulses, required 1", idle_n - i0);
      end
      tests_run++;
      if (waited < 290 || waited > 360) begin
         tests_failed++;
         $display("[TB] FAIL 8n1_idle_delay: got %0d clocks, required 290..360", waited);
      end
   endtask

   task automatic test_parity();
      int p0, e0;
      cfg_len = 3'd6; cfg_stop = 1'b1; cfg_parity = 2'b01;
      p0 = push_q.size(); e0 = err_n;
      send_frame(8'h41, 1'b1);
      wait_clks(4);
      tests_run++;
      if (err_n - e0 !== 1) begin
         tests_failed++;
         $display("[TB] FAIL parity_bad_error: got %0d, required 1", err_n - e0);
      end
      tests_run++;
      if (push_q.size() - p0 !== 0) begin
         tests_failed++;
         $display("[TB] FAIL parity_bad_push: got %0d, required 0", push_q.size() - p0);
      end
      send_frame(8'h41, 1'b0);
      wait_clks(4);
      tests_run++;
      if (push_q.size() - p0 !== 1 || push_q[push_q.size()-1] !== 8'h41) begin
         tests_failed++;
         $display("[TB] FAIL parity_good_push: got %0d pushes last %h, required 1 push of 41",
                  push_q.size() - p0, push_q[push_q.size()-1]);
      end
      tests_run++;
      if (err_n - e0 !== 1) begin
         tests_failed++;
         $display("[TB] FAIL parity_good_error: got %0d, required 1", err_n - e0);
      end
      cfg_len = 3'd7; cfg_stop = 1'b0; cfg_parity = 2'b00;
   endtask

   task automatic test_glitch();
      int p0, e0;
      p0 = push_q.size(); e0 = err_n;
      rxd = 1'b0;
      wait_clks(8);
      rxd = 1'b1;
      wait_clks(3 * bit_clks());
      tests_run++;
      if (push_q.size() - p0 !== 0 || err_n - e0 !== 0 || valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL glitch_activity: got pushes %0d errors %0d valid %b, required 0 0 0",
                  push_q.size() - p0, err_n - e0, valid);
      end
      send_frame(8'h5A, 1'b0);
      wait_clks(4);
      tests_run++;
      if (push_q.size() - p0 !== 1 || push_q[push_q.size()-1] !== 8'h5A) begin
         tests_failed++;
         $display("[TB] FAIL glitch_then_frame: got %0d pushes last %h, required 1 push of 5a",
                  push_q.size() - p0, push_q[push_q.size()-1]);
      end
   endtask

   task automatic test_overrun();
      int p0, o0;
      ready = 1'b0;
      p0 = push_q.size(); o0 = ovr_n;
      send_frame(8'h11, 1'b0);
      send_frame(8'h22, 1'b0);
      wait_clks(4);
      tests_run++;
      if (valid !== 1'b1 || payload !== 8'h11) begin
         tests_failed++;
         $display("[TB] FAIL overrun_hold: got valid %b payload %h, required 1 11", valid, payload);
      end
      tests_run++;
      if (ovr_n - o0 !== 1) begin
         tests_failed++;
         $display("[TB] FAIL overrun_pulse: got %0d, required 1", ovr_n - o0);
      end
      ready = 1'b1;
      wait_clks(4);
      tests_run++;
      if (push_q.size() - p0 !== 1 || push_q[push_q.size()-1] !== 8'h11 || valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL overrun_drain: got %0d pushes last %h valid %b, required 1 push of 11 valid 0",
                  push_q.size() - p0, push_q[push_q.size()-1], valid);
      end
   endtask

   task automatic test_break();
      int p0, e0;
      p0 = push_q.size(); e0 = err_n;
      rxd = 1'b0;
      wait_clks(20 * bit_clks());
      tests_run++;
      if (read_break !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL break_level: got %b, required 1", read_break);
      end
      tests_run++;
      if (err_n - e0 !== 1 || push_q.size() - p0 !== 0) begin
         tests_failed++;
         $display("[TB] FAIL break_error: got errors %0d pushes %0d, required 1 0",
                  err_n - e0, push_q.size() - p0);
      end
      rxd = 1'b1;
      wait_clks(6);
      tests_run++;
      if (read_break !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL break_release: got %b, required 0", read_break);
      end
      wait_clks(2 * bit_clks());
   endtask

   task automatic test_reset_abort();
      logic [15:0] bits;
      int n, p0, e0;
      ready = 1'b0;
      send_frame(8'h77, 1'b0);
      wait_clks(4);
      tests_run++;
      if (valid !== 1'b1 || payload !== 8'h77) begin
         tests_failed++;
         $display("[TB] FAIL abort_pending: got valid %b payload %h, required 1 77", valid, payload);
      end
      build_frame(8'h99, 1'b0, bits, n);
      drive_bits(bits, 5);
      rst_n = 1'b0;
      rxd = 1'b1;
      wait_clks(3);
      tests_run++;
      if ({valid, payload, read_error, overrun, read_break, rx_idle} !== 13'h0) begin
         tests_failed++;
         $display("[TB] FAIL midframe_reset: got %h, required 0",
                  {valid, payload, read_error, overrun, read_break, rx_idle});
      end
      rst_n = 1'b1;
      ready = 1'b1;
      wait_clks(12 * bit_clks());
      p0 = push_q.size(); e0 = err_n;
      drive_bits(bits, 4);
      rxen = 1'b0;
      drive_bits(bits >> 4, n - 4);
      rxd = 1'b1;
      wait_clks(2 * bit_clks());
      rxen = 1'b1;
      wait_clks(2 * bit_clks());
      tests_run++;
      if (push_q.size() - p0 !== 0 || err_n - e0 !== 0) begin
         tests_failed++;
         $display("[TB] FAIL rxen_abort: got pushes %0d errors %0d, required 0 0",
                  push_q.size() - p0, err_n - e0);
      end
      send_frame(8'h3C, 1'b0);
      wait_clks(4);
      tests_run++;
      if (push_q.size() - p0 !== 1 || push_q[push_q.size()-1] !== 8'h3C) begin
         tests_failed++;
         $display("[TB] FAIL after_abort_frame: got %0d pushes last %h, required 1 push of 3c",
                  push_q.size() - p0, push_q[push_q.size()-1]);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rxd = 1'b1;
      rxen = 1'b1;
      ready = 1'b1;
      cfg_div = 20'd3;
      cfg_len = 3'd7;
      cfg_stop = 1'b0;
      cfg_parity = 2'b00;
      wait_clks(3);
      test_reset();
      test_8n1();
      test_parity();
      test_glitch();
      test_overrun();
      test_break();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive engine for the USART peripheral: deserialises the `rxd` line into bytes and pushes them into the RX stream FIFO through a valid/ready stream. It applies the same frame configuration the APB register block drives into the transmitter: data length, stop bits, parity and clock divider. It also produces the parity/frame error pulse, break level and idle pulse that feed the status register and interrupt logic.

## Interface
- No parameters; all configuration is run-time.
- `io_mainClk`  in  1  sole clock.
- `resetCtrl_systemResetn`  in  1  reset; asynchronous assert, active-low.
- `io_config_frame_dataLength`  in  3  data bits minus 1 (7 = 8 bits, 0 = 1 bit).
- `io_config_frame_stop`  in  1  0 = one stop bit, 1 = two stop bits.
- `io_config_frame_parity`  in  2  {PS, PCE}: PCE = parity enable, PS = 1 odd / 0 even.
- `io_config_clockDivider`  in  20  sample tick every (value+1) clocks; 8 ticks per bit.
- `io_uart_rxen`  in  1  receiver enable.
- `io_uart_rxd`  in  1  asynchronous serial input, idle high.
- `io_read_valid`  out  1  byte available.
- `io_read_ready`  in  1  FIFO push ready.
- `io_read_payload`  out  8  received byte, LSB first, unused upper bits zero.
- `io_readError`  out  1  one-cycle pulse on parity or stop-bit error.
- `io_overrun`  out  1  one-cycle pulse when a good byte is dropped.
- `io_readBreak`  out  1  level, line held low for a full frame.
- `io_rxIdle`  out  1  one-cycle pulse after 10 idle bit times following a frame.

## Operation
- `rxd` passes a 2-FF synchroniser; both flops reset to 1. All decisions use the synchronised value.
- Tick divider:
  - Counter runs 0..clockDivider and pulses `tick` at wrap.
  - It is held at 0 while `rxen` = 0, and is also cleared on start-edge detection.
- FSM states and transitions:
  - IDLE: a falling synchronised `rxd` with `rxen` = 1 moves to START.
  - START: evaluates the start bit.
  - DATA: runs `dataLength`+1 bits.
  - PARITY: entered only if PCE = 1.
  - STOP1, then STOP2 if stop = 1.
  - Return to IDLE.
- Bit sampling:
  - Each bit spans tick counts 0..7.
  - Bit value = majority of the samples at ticks 3, 4 and 5.
  - Decision is taken at tick 5.
- Start bit:
  - Majority 1 is a false start: return to IDLE, no flags.
  - Majority 0 continues; the bit window completes at tick 7.
- Data: shift register, LSB first; bit k of payload = k-th data bit.
- Parity: expected value = XOR of data bits, XOR PS. A mismatch marks the frame bad.
- Stop bits:
  - Each stop bit must sample 1.
  - At the last stop bit's tick-5 decision the FSM returns to IDLE, so the next start edge can be detected mid-stop.
- Frame result at the last stop decision:
  - Good frame: load the output register and set `valid`.
  - Bad frame: pulse `readError`, no push.
  - Break: data, parity and stop all 0. Pulse `readError`, set `readBreak`, no push. `readBreak` clears when synchronised `rxd` returns to 1.
- Output stream:
  - `valid`/`payload` are held until `valid && ready`.
  - A new good byte completing while `valid && !ready` is discarded and `io_overrun` pulses; the old byte is kept.
- Idle detection:
  - Armed after any frame completes.
  - Counts bit windows with `rxd` = 1.
  - At 10 windows, pulses `io_rxIdle` once and disarms.
  - A start edge disarms it without a pulse.
- `rxen` falling mid-frame aborts to IDLE with no flags. A pending `valid` is not cleared.
- Configuration changes mid-frame are unsupported; the new values take effect on the next start.

## Timing
- Reset values:
  - All outputs 0, FSM in IDLE.
  - Divider 0, shift register 0.
  - Synchroniser 1, idle detector disarmed.
- Input latency: 2 clocks from an `rxd` change to the synchronised value.
- `valid` rises 1 clock after the tick-5 decision of the last stop bit. Same cycle for `readError`/`overrun` pulses.
- `valid` falls the clock after the handshake. Back-to-back frames need ready within one frame time.
- Divider = 0 is legal: a tick every clock, 8 clocks per bit.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum.
  - Parity bit-position constants (PCE = 0, PS = 1).
  - Ticks-per-bit = 8, idle-bit-count = 10.
  - Config struct typedef shared with the TX controller.
- One sub-module, `uart_baud_tick`: the divider with enable and synchronous clear. The TX side reuses it.

## Test plan
- Divider 3 (32 clocks/bit), 8N1, send 0x55 then 0xA3, ready = 1 → two pushes of 0x55 and 0xA3; no error; `rxIdle` pulses ~10 bit times after the second stop.
- 7E2 (dataLength 6, PCE = 1, PS = 0, stop = 1), send 0x41 with a wrong parity bit → `readError` pulse, no push. Then send a correct 0x41 → push 0x41.
- Start glitch: `rxd` low for 8 clocks at divider 3 → no activity, FSM back in IDLE.
- Hold ready = 0, send 0x11 then 0x22 → payload stays 0x11, `overrun` pulses at the end of the second frame. After ready is raised, a single push of 0x11.
- `rxd` low for 2 frame times, 8N1 → one `readError`, `readBreak` high until `rxd` rises, no push.
- Reset asserted mid-data and `rxen` dropped mid-frame → outputs return to reset values / IDLE. The next frame 0x3C is received correctly.
